// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, 2-of-3 majority per bit, false-start rejection,
// framing-error reporting and break detection.
module uart_rx_core #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned MID    = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta, rx_s, rx_prev;
    logic [1:0]           sync_fill;
    logic                 armed;
    logic [DIV_W-1:0]     tick_cnt;
    logic [SAMP_W-1:0]    sample_cnt;
    logic                 samp_a, samp_b;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] rx_data_d;
    logic                 rx_valid_d, frame_err_d, busy_d;
    logic                 start_edge_c, tick_c, decide_c, maj_c;

    // Two-flop synchronizer; armed only once a genuine high level has been seen after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_edge_c = (state_q == IDLE) && armed && rx_prev && !rx_s;
    assign tick_c       = (tick_cnt == DIV_W'(DIV - 1)) && !start_edge_c;
    assign decide_c     = tick_c && (sample_cnt == SAMP_W'(MID + 1));
    assign maj_c        = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    // Baud tick divider, realigned to the start edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (start_edge_c || tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    // Sample position within the bit and the two early majority samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
        end else if (start_edge_c) begin
            sample_cnt <= '0;
        end else if (tick_c) begin
            if (sample_cnt == SAMP_W'(OVERSAMPLE - 1)) begin
                sample_cnt <= '0;
            end else begin
                sample_cnt <= sample_cnt + SAMP_W'(1);
            end
            if (sample_cnt == SAMP_W'(MID - 1)) begin
                samp_a <= rx_s;
            end
            if (sample_cnt == SAMP_W'(MID)) begin
                samp_b <= rx_s;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
            busy      <= busy_d;
        end
    end

    // Next-state and output decode; decisions are made on the mid+1 sample tick
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge_c) begin
                    state_d = START;
                end
            end
            START: begin
                if (decide_c) begin
                    if (maj_c) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (decide_c) begin
                    shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (decide_c) begin
                    if (maj_c) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A frame is in progress only between start and stop; break wait is not busy
        busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at DIV=10 (160 clk per bit).
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad = 0;

    int         cyc = 0;
    int         vcyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         overlap = 0;
    int         busy_viol = 0;
    bit         prev_pulse = 1'b0;
    logic [7:0] data_log [0:15];

    uart_rx_core #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (10_000),
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor
    always @(negedge clk) begin
        if (rx_valid) begin
            data_log[n_valid % 16] <= rx_data;
            n_valid <= n_valid + 1;
            vcyc <= cyc;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (rx_valid && frame_err) overlap <= overlap + 1;
        if (prev_pulse && busy) busy_viol <= busy_viol + 1;
        prev_pulse <= rx_valid | frame_err;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int bitlen, input logic stop_val);
        rx = 1'b0;
        wait_clk(bitlen);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(bitlen);
        end
        rx = stop_val;
        wait_clk(bitlen);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        wait_clk(3);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        // Line stuck low across reset release must not look like a start edge
        rx = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(300);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stuck_low_busy got=%b exp=0", busy); end
        total++; if (n_valid !== 0 || n_ferr !== 0) begin bad++; $display("FAIL stuck_low_pulses valid=%0d ferr=%0d exp=0/0", n_valid, n_ferr); end
        rx = 1'b1;
        wait_clk(200);
    endtask

    task automatic test_single_frame;
        int base_v, base_f, start_c, lat;
        base_v = n_valid;
        base_f = n_ferr;
        start_c = cyc;
        send_frame(8'hA5, 160, 1'b1);
        wait_clk(50);
        lat = vcyc - start_c;
        total++; if (n_valid !== base_v + 1) begin bad++; $display("FAIL a5_count got=%0d exp=%0d", n_valid, base_v + 1); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h exp=a5", rx_data); end
        total++; if (lat < 1536 || lat > 1544) begin bad++; $display("FAIL a5_latency got=%0d exp=1540+/-4", lat); end
        total++; if (n_ferr !== base_f) begin bad++; $display("FAIL a5_ferr got=%0d exp=%0d", n_ferr, base_f); end
    endtask

    task automatic test_glitch;
        int base_v, base_f;
        bit cleared;
        base_v = n_valid;
        base_f = n_ferr;
        rx = 1'b0;
        wait_clk(30);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=%b exp=1", busy); end
        rx = 1'b1;
        cleared = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wait_clk(1);
            if (busy === 1'b0) begin
                cleared = 1'b1;
                break;
            end
        end
        total++; if (!cleared) begin bad++; $display("FAIL glitch_busy_clear got=%b exp=0 within 100 clk", busy); end
        wait_clk(300);
        total++; if (n_valid !== base_v) begin bad++; $display("FAIL glitch_valid got=%0d exp=%0d", n_valid, base_v); end
        total++; if (n_ferr !== base_f) begin bad++; $display("FAIL glitch_ferr got=%0d exp=%0d", n_ferr, base_f); end
    endtask

    task automatic test_framing_break;
        int base_v, base_f;
        base_v = n_valid;
        base_f = n_ferr;
        send_frame(8'h3C, 160, 1'b0);
        rx = 1'b0;
        total++; if (n_ferr !== base_f + 1) begin bad++; $display("FAIL ferr_count got=%0d exp=%0d", n_ferr, base_f + 1); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL ferr_data_held got=%h exp=a5", rx_data); end
        wait_clk(500);
        total++; if (n_ferr !== base_f + 1 || n_valid !== base_v) begin bad++; $display("FAIL break_pulses ferr=%0d valid=%0d exp=%0d/%0d", n_ferr, n_valid, base_f + 1, base_v); end
        rx = 1'b1;
        wait_clk(200);
        send_frame(8'h00, 160, 1'b1);
        wait_clk(50);
        total++; if (n_valid !== base_v + 1) begin bad++; $display("FAIL post_break_count got=%0d exp=%0d", n_valid, base_v + 1); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL post_break_data got=%h exp=00", rx_data); end
    endtask

    task automatic test_back_to_back;
        int base_v;
        base_v = n_valid;
        send_frame(8'h00, 160, 1'b1);
        send_frame(8'hFF, 160, 1'b1);
        send_frame(8'h55, 160, 1'b1);
        wait_clk(50);
        total++; if (n_valid !== base_v + 3) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", n_valid, base_v + 3); end
        total++; if (data_log[base_v % 16] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h exp=00", data_log[base_v % 16]); end
        total++; if (data_log[(base_v + 1) % 16] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h exp=ff", data_log[(base_v + 1) % 16]); end
        total++; if (data_log[(base_v + 2) % 16] !== 8'h55) begin bad++; $display("FAIL b2b_third got=%h exp=55", data_log[(base_v + 2) % 16]); end
    endtask

    task automatic test_mid_reset;
        int base_v, base_f;
        base_v = n_valid;
        base_f = n_ferr;
        fork
            send_frame(8'hF0, 160, 1'b1);
            begin
                wait_clk(5 * 160 + 80);
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
                rst_n = 1'b0;
                wait_clk(1);
                total++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL midrst_outputs data=%h valid=%b ferr=%b busy=%b exp=00/0/0/0", rx_data, rx_valid, frame_err, busy);
                end
                rst_n = 1'b1;
            end
        join
        wait_clk(200);
        total++; if (n_valid !== base_v || n_ferr !== base_f) begin bad++; $display("FAIL midrst_no_pulse valid=%0d ferr=%0d exp=%0d/%0d", n_valid, n_ferr, base_v, base_f); end
        send_frame(8'h81, 160, 1'b1);
        wait_clk(50);
        total++; if (n_valid !== base_v + 1) begin bad++; $display("FAIL midrst_next_count got=%0d exp=%0d", n_valid, base_v + 1); end
        total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL midrst_next_data got=%h exp=81", rx_data); end
    endtask

    task automatic test_baud_tolerance;
        int base_v;
        base_v = n_valid;
        send_frame(8'h96, 155, 1'b1);
        wait_clk(100);
        total++; if (n_valid !== base_v + 1) begin bad++; $display("FAIL fast_count got=%0d exp=%0d", n_valid, base_v + 1); end
        total++; if (rx_data !== 8'h96) begin bad++; $display("FAIL fast_data got=%h exp=96", rx_data); end
        send_frame(8'h96, 165, 1'b1);
        wait_clk(100);
        total++; if (n_valid !== base_v + 2) begin bad++; $display("FAIL slow_count got=%0d exp=%0d", n_valid, base_v + 2); end
        total++; if (rx_data !== 8'h96) begin bad++; $display("FAIL slow_data got=%h exp=96", rx_data); end
    endtask

    task automatic test_pulse_rules;
        total++; if (overlap !== 0) begin bad++; $display("FAIL pulse_overlap got=%0d exp=0", overlap); end
        total++; if (busy_viol !== 0) begin bad++; $display("FAIL busy_after_pulse got=%0d exp=0", busy_viol); end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_glitch;
        test_framing_break;
        test_back_to_back;
        test_mid_reset;
        test_baud_tolerance;
        test_pulse_rules;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
